// File: rtl/encoder_pkg.sv
// Shared types and widths for the 8-to-3 request encoder.
// Holds the FSM state type and the request-bit clear-mask helper.
package encoder_pkg;

    localparam int REQ_W  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    // 3-to-8 one-hot decode of a served code, used to clear that pending bit
    function automatic logic [REQ_W-1:0] code_to_mask(input logic [CODE_W-1:0] code);
        return REQ_W'(1) << code;
    endfunction

endpackage

// File: rtl/priority_encoder_8.sv
// Combinational 8-bit vector to 3-bit index encoder with an any-set flag.
// Default selects the highest set bit; PRIORITY_LSB_FIRST_EN selects the lowest.
module priority_encoder_8
    import encoder_pkg::*;
(
    input  logic [REQ_W-1:0]  i_vec,
    output logic [CODE_W-1:0] o_idx,
    output logic              o_any
);

    always_comb begin
        o_idx = '0;
`ifdef PRIORITY_LSB_FIRST_EN
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = CODE_W'(i);
        end
`else
        for (int i = 0; i < REQ_W; i++) begin
            if (i_vec[i]) o_idx = CODE_W'(i);
        end
`endif
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/request_encoder_8_to_3.sv
// Captures an 8-bit request vector and emits one code per handshake in priority order.
// Service order is descending by default, ascending with PRIORITY_LSB_FIRST_EN.
module request_encoder_8_to_3
    import encoder_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Enable,
    input  logic              Load,
    input  logic [REQ_W-1:0]  Req_In,
    output logic              Ready,
    input  logic              Out_Ready,
    output logic              Valid,
    output logic [CODE_W-1:0] Encode_Out,
    output logic              Zero_Flag
);

    state_t            r_state;
    state_t            w_state_next;
    logic [REQ_W-1:0]  r_pending;
    logic [REQ_W-1:0]  w_pending_next;
    logic [REQ_W-1:0]  w_remaining;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_idx;
    logic              r_zero;
    logic              w_zero_next;
    logic              w_any;
    logic              w_valid;
    logic              w_handshake;

    priority_encoder_8 u_prio (
        .i_vec (r_pending),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_valid     = (r_state == SERVE) && Enable && w_any;
    assign w_handshake = w_valid && Out_Ready;
    assign w_remaining = r_pending & ~code_to_mask(Encode_Out);

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_zero_next    = 1'b0;
        if (Enable) begin
            case (r_state)
                IDLE: begin
                    if (Load) begin
                        w_pending_next = Req_In;
                        if (|Req_In) begin
                            w_state_next = SERVE;
                        end else begin
                            w_zero_next = 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (w_handshake) begin
                        w_pending_next = w_remaining;
                        if (w_remaining == '0) w_state_next = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_code    <= '0;
            r_zero    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_zero    <= w_zero_next;
            if (w_valid) r_code <= w_idx;
        end
    end

    // Show the live code while valid, otherwise the last code presented
    assign Encode_Out = w_valid ? w_idx : r_code;
    assign Ready      = (r_state == IDLE);
    assign Valid      = w_valid;
    assign Zero_Flag  = r_zero;

endmodule

// File: tb/tb_request_encoder_8_to_3.sv
// Scoreboard bench for request_encoder_8_to_3: directed scenarios plus random traffic.
// The expected code stream is built from the set bits of each accepted vector.
module tb_request_encoder_8_to_3;

    logic       Clk;
    logic       Rst_n;
    logic       Enable;
    logic       Load;
    logic [7:0] Req_In;
    logic       Ready;
    logic       Out_Ready;
    logic       Valid;
    logic [2:0] Encode_Out;
    logic       Zero_Flag;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];
    int last_code = 0;
    int exp_zero  = 0;
    int mon_exp_v;

    request_encoder_8_to_3 dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Enable     (Enable),
        .Load       (Load),
        .Req_In     (Req_In),
        .Ready      (Ready),
        .Out_Ready  (Out_Ready),
        .Valid      (Valid),
        .Encode_Out (Encode_Out),
        .Zero_Flag  (Zero_Flag)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the accepted vector is served as its set-bit indices in priority order
    task automatic push_codes(input logic [7:0] v);
        int idx_q[$];
        for (int i = 0; i < 8; i++) if (v[i]) idx_q.push_back(i);
`ifdef PRIORITY_LSB_FIRST_EN
        idx_q.sort();
`else
        idx_q.rsort();
`endif
        foreach (idx_q[k]) exp_q.push_back(idx_q[k]);
    endtask

    // Called at posedge+1; the queue is empty exactly when the DUT is idle here
    task automatic do_cycle(input logic en, input logic ld, input logic [7:0] v,
                            input logic ordy);
        bit accept;
        Enable    = en;
        Load      = ld;
        Req_In    = v;
        Out_Ready = ordy;
        chk("ready", Ready, exp_q.size() == 0);
        accept = en && ld && (exp_q.size() == 0);
        @(posedge Clk);
        if (accept) begin
            if (v != 8'h00) push_codes(v);
            else exp_zero = 1;
        end
        #1;
    endtask

    always @(negedge Clk) begin
        if (Rst_n) begin
            mon_exp_v = (Enable && exp_q.size() != 0) ? 1 : 0;
            chk("valid", Valid, mon_exp_v);
            if (mon_exp_v != 0) begin
                chk("code", Encode_Out, exp_q[0]);
                last_code = exp_q[0];
                if (Out_Ready) void'(exp_q.pop_front());
            end else begin
                chk("code_hold", Encode_Out, last_code);
            end
            chk("zero_flag", Zero_Flag, exp_zero);
            exp_zero = 0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, Valid, 0);
        chk({tag, "_ready"}, Ready, 1);
        chk({tag, "_code"}, Encode_Out, 0);
        chk({tag, "_zero"}, Zero_Flag, 0);
    endtask

    initial begin
        Rst_n     = 1'b0;
        Enable    = 1'b0;
        Load      = 1'b0;
        Req_In    = 8'h00;
        Out_Ready = 1'b0;
        #3;
        check_reset_outputs("por");
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // First load right after reset release; Out_Ready held high
        do_cycle(1, 1, 8'b1010_0100, 1);
        repeat (4) do_cycle(1, 0, 8'h00, 1);

        // All-zero vector: one-cycle Zero_Flag, stays idle
        do_cycle(1, 1, 8'h00, 1);
        repeat (2) do_cycle(1, 0, 8'h00, 1);

        // Full vector with Out_Ready toggling; Load attempts while busy are ignored
        do_cycle(1, 1, 8'hFF, 0);
        for (int i = 0; i < 18; i++) do_cycle(1, i[0], 8'h3C, i[0]);
        repeat (2) do_cycle(1, 0, 8'h00, 1);

        // Freeze after the first handshake
        do_cycle(1, 1, 8'h11, 1);
        do_cycle(1, 0, 8'h00, 1);
        repeat (3) do_cycle(0, 0, 8'h00, 1);
        repeat (3) do_cycle(1, 0, 8'h00, 1);

        // Asynchronous reset while a code is valid
        do_cycle(1, 1, 8'h81, 0);
        do_cycle(1, 0, 8'h00, 0);
        #2;
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        last_code = 0;
        exp_zero  = 0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        repeat (4) do_cycle(1, 0, 8'h00, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if ($urandom_range(0, 7) == 0) v = 8'h00;
            do_cycle(($urandom_range(0, 7) != 0), 1'($urandom), v, 1'($urandom));
        end

        // Drain outstanding codes with a bounded wait
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) do_cycle(1, 0, 8'h00, 1);
        chk("drain_timeout", exp_q.size(), 0);
        do_cycle(1, 0, 8'h00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
